// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//
// Purpose:
//   Registered immediate-decode stage between fetch and execute in the RV32I
//   core. It classifies each instruction's format from its opcode and
//   assembles the sign-extended immediate at XLEN width. A 2-entry skid
//   buffer (output register + skid register) gives full-throughput
//   valid/ready flow control. A flush squashes every held beat and the beat
//   on the input in the same cycle.
//
// Parameters:
//   XLEN         datapath width, 32 or 64
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous, active-low reset
//   flush        squash held beats and the current input beat
//   in_valid     input beat valid
//   in_ready     stage can accept a beat (registered)
//   in_instr     32-bit instruction word
//   in_pc        instruction address, passed through
//   out_valid    output beat valid
//   out_ready    downstream accepts the beat
//   out_instr    registered instruction
//   out_pc       registered PC
//   out_imm      assembled, sign-extended immediate
//   out_fmt      format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
//   out_illegal  unknown-opcode flag
//
// Configuration:
//   IMM_ILLEGAL_EN  when defined, unknown opcodes and instr[1:0] != 2'b11
//                   decode as ILL (fmt 7, imm 0) and raise out_illegal.
//                   When undefined, unknown opcodes decode as R and
//                   out_illegal is tied 0.
// -----------------------------------------------------------------------------
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    fmt_e            dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;

    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;

    logic in_xfer;
    logic out_xfer;
    logic out_load;
    logic skid_load;
    logic skid_valid_next;

    // Format classification from the opcode field.
    always_comb begin
        dec_fmt = FMT_R;
        case (in_instr[6:0])
            7'b0110011:                        dec_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:            dec_fmt = FMT_I;
            7'b0100011:                        dec_fmt = FMT_S;
            7'b1100011:                        dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:            dec_fmt = FMT_U;
            7'b1101111:                        dec_fmt = FMT_J;
`ifdef IMM_ILLEGAL_EN
            default:                           dec_fmt = FMT_ILL;
`else
            default:                           dec_fmt = FMT_R;
`endif
        endcase
`ifdef IMM_ILLEGAL_EN
        // Compressed/reserved encodings are never legal in this core.
        if (in_instr[1:0] != 2'b11) begin
            dec_fmt = FMT_ILL;
        end
`endif
    end

    // Immediate assembly at 32 bits; every format's sign bit is instr[31],
    // so widening to XLEN is a plain replication of bit 31.
    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
            FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_narrow
        assign dec_imm = dec_imm32[XLEN-1:0];
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_load  = !out_valid || out_xfer;
    // in_ready is low whenever the skid is occupied, so a skid load never
    // collides with a held skid entry.
    assign skid_load = in_xfer && out_valid && !out_xfer;

    always_comb begin
        skid_valid_next = skid_valid;
        if (skid_load) begin
            skid_valid_next = 1'b1;
        end else if (out_load) begin
            skid_valid_next = 1'b0;
        end
    end

    // Output register, skid register and registered in_ready. Flush clears
    // both entries; a beat leaving the output in the flush cycle has already
    // been taken downstream, so clearing out_valid is correct for it too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_pc     <= '0;
            out_imm    <= '0;
            out_fmt    <= 3'd0;
            skid_valid <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc    <= '0;
            skid_imm   <= '0;
            skid_fmt   <= 3'd0;
            in_ready   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (out_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_instr <= skid_instr;
                    out_pc    <= skid_pc;
                    out_imm   <= skid_imm;
                    out_fmt   <= skid_fmt;
                end else if (in_xfer) begin
                    out_valid <= 1'b1;
                    out_instr <= in_instr;
                    out_pc    <= in_pc;
                    out_imm   <= dec_imm;
                    out_fmt   <= dec_fmt;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (skid_load) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
                skid_imm   <= dec_imm;
                skid_fmt   <= dec_fmt;
            end
            skid_valid <= skid_valid_next;
            in_ready   <= !skid_valid_next;
        end
    end

`ifdef IMM_ILLEGAL_EN
    // ILL is the only format encoded as 7, so the flag follows the
    // registered format directly.
    assign out_illegal = (out_fmt == FMT_ILL);
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, handshaked immediate-decode pipeline stage sitting between fetch and execute in the RV32I core. It accepts one 32-bit instruction per cycle, classifies its format, and produces the fully assembled, sign-extended immediate at XLEN width. A 2-entry skid buffer provides full-throughput valid/ready flow control, and a flush input squashes in-flight beats on redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  squash all held beats and the current input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address, passed through.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_instr  out  32  registered instruction.
- out_pc  out  XLEN  registered PC.
- out_imm  out  XLEN  assembled, sign-extended immediate.
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  out  1  unknown opcode flag; see Configuration.

## Operation
- Opcode map:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediate assembly; sext means sign-extend from the MSB shown to XLEN:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). For XLEN=64, bit 31 replicates into [63:32].
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R and ILL: imm = 0.
- Decode is combinational on the input side. Results are captured into the output register, or into the skid register when the output is stalled.
- Transfer on the input side occurs when in_valid and in_ready are both high. Transfer on the output side occurs when out_valid and out_ready are both high.
- Output register loads when it is empty or its beat transfers this cycle. The source is the skid entry if the skid is valid, otherwise the input beat.
- Skid loads when an input beat transfers while the output register is full and not transferring.
- in_ready is registered and equals !skid_valid for the next cycle.
- Beat order is strictly preserved. No beat is dropped or duplicated except by flush.
- flush=1: next cycle out_valid=0 and skid_valid=0. The input beat in the same cycle is discarded. Flush takes priority over every transfer except an output transfer completing in that cycle.

## Timing
- Reset: while rst_n=0 at a clock edge, the following clear: out_valid=0, skid_valid=0, in_ready=0, out_imm=0, out_instr=0, out_pc=0, out_fmt=0, out_illegal=0.
- in_ready=1 from the first edge with rst_n=1.
- Input beats presented during reset are ignored.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N. Skid-held beats add one cycle per stalled cycle.
- Throughput: 1 beat/cycle with out_ready held high. in_ready stays 1.
- Stall: out_ready drops while out_valid=1. The output holds stable. One more input beat is captured into the skid, then in_ready=0 from the next cycle.
- Release: out_ready rises with the skid full. The skid moves to the output that cycle, and in_ready=1 the following cycle.
- Reset asserted mid-stream clears all state at that edge. No partial beat survives.

## Configuration
- IMM_ILLEGAL_EN defined:
  - An opcode outside the map sets out_fmt=7, out_imm=0 and out_illegal=1.
  - in_instr[1:0]!=2'b11 also sets out_fmt=7, out_imm=0 and out_illegal=1.
- IMM_ILLEGAL_EN undefined:
  - Unknown opcodes decode as R (out_fmt=0, out_imm=0).
  - out_illegal is tied 0 and no illegal-detect logic is present.

## Test plan
- XLEN=32, stream 0xFFF00093, 0x123450B7, 0xFE000EE3, 0x0010006F, 0xFE20AC23 with out_ready=1. Required output, one per cycle:
  - imm 0xFFFFFFFF, fmt 1
  - imm 0x12345000, fmt 4
  - imm 0xFFFFFFFC, fmt 3
  - imm 0x00000800, fmt 5
  - imm 0xFFFFFFF8, fmt 2
- XLEN=64: instr 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt 4. Instr 0x00000033 -> imm 0, fmt 0.
- Backpressure: stream beats A,B,C,D and hold out_ready=0 for 3 cycles starting when A is on the output.
  - A holds stable; B goes into the skid.
  - in_ready=0 while stalled.
  - After release, the outputs are A,B,C,D in order with no loss.
- Flush with skid full and in_valid=1: next cycle out_valid=0 and in_ready=1. The following accepted beat emerges one cycle later.
- Reset mid-stream with rst_n=0 for one cycle: all outputs and in_ready read 0 at that edge; in_ready=1 the edge after release.
- IMM_ILLEGAL_EN defined, instr 0x0000007F -> fmt 7, illegal 1, imm 0. With the macro undefined, the same instr gives fmt 0, illegal 0.
